// File: rtl/ysyx_22050133_mdu_seq.sv
// ysyx_22050133_mdu_seq: iterative RV64M multiply/divide sequencer for EXU.
// Shift-add multiplier and restoring divider share one 128-bit accumulator and
// run 64 steps (32 for W ops). Results are held until the consumer accepts them.
// Optional macro YSYX_22050133_MDU_FAST_MUL_EN: multiplies use one combinational
// 128-bit product and finish in a single cycle; divide stays iterative.
module ysyx_22050133_mdu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic        word,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  state_t       state_nx;
  logic [5:0]   cnt;

  // latched request and datapath registers
  logic [2:0]   op_q;
  logic         word_q;
  logic         neg_q;
  logic         aneg_q;
  logic [63:0]  opb;
  logic [127:0] acc;

  // request decode
  logic         fire;
  logic         is_div;
  logic         sign_a;
  logic         sign_b;
  logic         a_neg;
  logic         b_neg;
  logic         div0;
  logic         ovf;
  logic         special;
  logic         fast_mul;
  logic [63:0]  a64;
  logic [63:0]  b64;
  logic [63:0]  a_mag;
  logic [63:0]  b_mag;
  logic [63:0]  min_neg;
  logic [63:0]  div_spec;
  logic [63:0]  fast_res;
  logic [63:0]  spec_res;

  // iteration step and finishing fix-up
  logic [64:0]  mul_sum;
  logic [64:0]  div_sh;
  logic [64:0]  div_diff;
  logic [127:0] acc_nx;
  logic [127:0] mul_prod;
  logic [63:0]  quo;
  logic [63:0]  q_res;
  logic [63:0]  r_res;
  logic [63:0]  fin_res;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ext32(input logic [31:0] v, input logic sgn);
    return sgn ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

  // every W result is the sign extension of its low 32 bits
  function automatic logic [63:0] wfix(input logic w, input logic [63:0] v);
    return w ? sext32(v[31:0]) : v;
  endfunction

  function automatic logic [63:0] neg_if(input logic n, input logic [63:0] v);
    return n ? -v : v;
  endfunction

  // operand preparation: width extension, signs, magnitudes, special cases
  always_comb begin
    is_div  = op[2];
    fire    = in_valid && in_ready && !flush;
    // W variants: DIVU/REMU zero-extend, everything else sign-extends
    a64     = word ? ext32(src1[31:0], !(is_div && op[0])) : src1;
    b64     = word ? ext32(src2[31:0], !(is_div && op[0])) : src2;
    // W multiplies only need the low 32 product bits, which are sign-agnostic
    sign_a  = is_div ? !op[0] : (!word && (op == 3'd1 || op == 3'd2));
    sign_b  = is_div ? !op[0] : (!word && op == 3'd1);
    a_neg   = sign_a && a64[63];
    b_neg   = sign_b && b64[63];
    a_mag   = neg_if(a_neg, a64);
    b_mag   = neg_if(b_neg, b64);
    min_neg = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div0    = (b64 == 64'd0);
    ovf     = is_div && !op[0] && (a64 == min_neg) && (b64 == '1);
    if (div0)
      div_spec = op[1] ? a64 : '1;
    else
      div_spec = op[1] ? 64'd0 : a64;
    special  = is_div ? (div0 || ovf) : fast_mul;
    spec_res = wfix(word, is_div ? div_spec : fast_res);
  end

`ifdef YSYX_22050133_MDU_FAST_MUL_EN
  logic signed [64:0]  fa;
  logic signed [64:0]  fb;
  logic signed [127:0] fp;

  // single-cycle product; operands carry an explicit sign bit so MULHSU/MULHU fit
  always_comb begin
    fa       = {sign_a && a64[63], a64};
    fb       = {sign_b && b64[63], b64};
    fp       = 128'(fa) * 128'(fb);
    fast_mul = !is_div;
    if (word)
      fast_res = sext32(fp[31:0]);
    else
      fast_res = (op[1:0] == 2'd0) ? fp[63:0] : fp[127:64];
  end
`else
  // multiplies always take the iterative path
  always_comb begin
    fast_mul = 1'b0;
    fast_res = 64'd0;
  end
`endif

  // one multiply or divide step, plus the sign fix-up used on the final step
  always_comb begin
    mul_sum  = {1'b0, acc[127:64]} + (acc[0] ? {1'b0, opb} : 65'd0);
    div_sh   = {acc[127:64], acc[63]};
    div_diff = div_sh - {1'b0, opb};
    if (op_q[2])
      acc_nx = {(div_diff[64] ? div_sh[63:0] : div_diff[63:0]), acc[62:0], ~div_diff[64]};
    else
      acc_nx = {mul_sum, acc[63:1]};
    mul_prod = neg_q ? -acc_nx : acc_nx;
    quo      = word_q ? {32'b0, acc_nx[31:0]} : acc_nx[63:0];
    q_res    = neg_if(neg_q, quo);
    r_res    = neg_if(aneg_q, acc_nx[127:64]);
    if (op_q[2])
      fin_res = wfix(word_q, op_q[1] ? r_res : q_res);
    else if (word_q)
      // after 32 right shifts the low product word sits at acc[63:32]
      fin_res = sext32(acc_nx[63:32]);
    else
      fin_res = (op_q[1:0] == 2'd0) ? mul_prod[63:0] : mul_prod[127:64];
  end

  // next-state and handshake outputs, decoded from the state register
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !flush)
          state_nx = special ? DONE : CALC;
      end
      CALC: begin
        if (cnt == 6'd0)
          state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush)
      state_nx = IDLE;
  end

  // state register and iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nx;
      if (fire)
        cnt <= word ? 6'd31 : 6'd63;
      else if (state == CALC)
        cnt <= cnt - 6'd1;
    end
  end

  // operand latch on accept; accumulator steps while iterating
  always_ff @(posedge clk) begin
    if (fire) begin
      op_q   <= op;
      word_q <= word;
      neg_q  <= a_neg ^ b_neg;
      aneg_q <= a_neg;
      if (is_div) begin
        opb <= b_mag;
        // W dividends start in the top half so their MSB is shifted in first
        acc <= {64'd0, (word ? {a_mag[31:0], 32'd0} : a_mag)};
      end else begin
        opb <= a_mag;
        acc <= {64'd0, b_mag};
      end
    end else if (state == CALC) begin
      acc <= acc_nx;
    end
  end

  // result register: written by special cases or the last step, never by flush
  always_ff @(posedge clk) begin
    if (rst)
      result <= 64'd0;
    else if (fire && special)
      result <= spec_res;
    else if (state == CALC && cnt == 6'd0 && !flush)
      result <= fin_res;
  end

endmodule

// File: tb/tb_ysyx_22050133_mdu_seq.sv
// Bench for ysyx_22050133_mdu_seq: vector table, random ops against a native
// arithmetic model, and hand-written backpressure / flush / reset sequences.
module tb_ysyx_22050133_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef YSYX_22050133_MDU_FAST_MUL_EN
  localparam int ML64 = 1;
  localparam int ML32 = 1;
`else
  localparam int ML64 = 65;
  localparam int ML32 = 33;
`endif

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[18];
  logic [63:0] last_exp;

  always #5 clk = ~clk;

  ysyx_22050133_mdu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic checkb(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa;
    logic signed [127:0] pb;
    logic [127:0]        p;
    logic signed [63:0]  sa;
    logic signed [63:0]  sbv;
    logic signed [31:0]  sa32;
    logic signed [31:0]  sb32;
    logic [31:0]         ua;
    logic [31:0]         ub;
    logic [31:0]         r32;
    logic [63:0]         r;
    sa = a; sbv = b; ua = a[31:0]; ub = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
    r = 64'd0; r32 = 32'd0;
    if (w) begin
      case (o)
        3'd4: r32 = (ub == 0) ? 32'hFFFF_FFFF :
                    (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) ? ua : 32'(sa32 / sb32);
        3'd5: r32 = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
        3'd6: r32 = (ub == 0) ? ua :
                    (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa32 % sb32);
        3'd7: r32 = (ub == 0) ? ua : ua % ub;
        default: r32 = ua * ub;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        3'd0: r = a * b;
        3'd1: begin
          pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; r = p[127:64];
        end
        3'd2: begin
          pa = {{64{a[63]}}, a}; pb = {64'd0, b}; p = pa * pb; r = p[127:64];
        end
        3'd3: begin
          p = {64'd0, a} * {64'd0, b}; r = p[127:64];
        end
        3'd4: r = (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && b == '1) ? a : 64'(sa / sbv);
        3'd5: r = (b == 0) ? '1 : a / b;
        3'd6: r = (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && b == '1) ? 64'd0 : 64'(sa % sbv);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (!o[2]) return w ? ML32 : ML64;
    if (w) begin
      if (b[31:0] == 0) return 1;
      if (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 0) return 1;
    if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // drive one request from IDLE, wait for its result, compare and consume it
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] want, input int lat,
                       input string name);
    exp_t e;
    int   n;
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    e.res = want; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      checkb({name, " timeout"}, 1'b0, 1'b1);
    end else begin
      check({name, " lat"}, 64'(n), 64'(e.lat));
      check({name, " res"}, result, e.res);
      last_exp = e.res;
      @(negedge clk);
      checkb({name, " in_ready"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic        seen;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra;
    logic [63:0] rb;

    vt[0]  = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    vt[1]  = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};
    vt[2]  = '{3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vt[3]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vt[4]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vt[5]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vt[6]  = '{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vt[7]  = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vt[8]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, ML64};
    vt[9]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, ML64};
    vt[10] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ML32};
    vt[11] = '{3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd3, 64'h369D_0369_D036_9CD0, ML64};
    vt[12] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ML64};
    vt[13] = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vt[14] = '{3'd6, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
    vt[15] = '{3'd4, 1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vt[16] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vt[17] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};

    rst = 1'b1; in_valid = 1'b0; op = 3'd0; word = 1'b0; src1 = 64'd0; src2 = 64'd0;
    flush = 1'b0; out_ready = 1'b1; last_exp = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkb("reset in_ready", in_ready, 1'b1);
    checkb("reset out_valid", out_valid, 1'b0);
    checkb("reset busy", busy, 1'b0);
    check("reset result", result, 64'd0);

    for (int i = 0; i < 18; i++)
      do_op(vt[i].op, vt[i].w, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 2));
      do_op(ro, rw, ra, rb, ref_res(ro, rw, ra, rb), ref_lat(ro, rw, ra, rb), $sformatf("rnd%0d", i));
    end

    // backpressure: result held while out_ready is low, new requests ignored
    out_ready = 1'b0;
    op = 3'd5; word = 1'b0; src1 = 64'd50; src2 = 64'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp lat", 64'(n), 64'd65);
    for (int k = 0; k < 10; k++) begin
      checkb("bp out_valid", out_valid, 1'b1);
      check("bp result", result, 64'd10);
      checkb("bp in_ready", in_ready, 1'b0);
      in_valid = 1'b1; op = 3'd0; src1 = 64'd3; src2 = 64'd3;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkb("bp in_ready after", in_ready, 1'b1);
    checkb("bp out_valid after", out_valid, 1'b0);
    check("bp result after", result, 64'd10);
    last_exp = 64'd10;

    // flush 20 cycles into a DIV
    op = 3'd4; word = 1'b0; src1 = 64'd1000; src2 = 64'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkb("flush busy", busy, 1'b0);
    checkb("flush in_ready", in_ready, 1'b1);
    checkb("flush out_valid", out_valid, 1'b0);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkb("flush never valid", seen, 1'b0);
    check("flush result kept", result, last_exp);
    do_op(3'd5, 1'b0, 64'd9, 64'd3, 64'd3, 65, "post-flush divu");

    // flush in IDLE drops a concurrent request
    op = 3'd5; word = 1'b0; src1 = 64'd8; src2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checkb("idle flush busy", busy, 1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkb("idle flush dropped", seen, 1'b0);

    // reset in the middle of a multiply
    op = 3'd3; word = 1'b0; src1 = 64'd123; src2 = 64'd456; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst result", result, 64'd0);
    checkb("midrst out_valid", out_valid, 1'b0);
    checkb("midrst in_ready", in_ready, 1'b1);
    checkb("midrst busy", busy, 1'b0);
    do_op(3'd0, 1'b0, 64'd6, 64'd7, 64'd42, ML64, "post-rst mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050133_mdu_seq.md
# ysyx_22050133_mdu_seq

Iterative RV64M multiply/divide sequencer sitting beside the ALU in EXU. Accepts one M-extension operation (funct3-encoded, optional W variant) over a valid/ready handshake, runs a shift-add multiplier or restoring divider for 64 or 32 cycles, and holds the result until EXU consumes it. The decoder-side ALUop for MUL..REMU is mapped to `op` by EXU; pipeline stall is driven from `busy`.

## Interface
- no parameters
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE; handshake when in_valid&in_ready&!flush
- op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- word  in  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW)
- src1  in  64  rs1 operand
- src2  in  64  rs2 operand
- flush  in  1  kill in-flight op (branch/trap redirect)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  64  result, registered
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE. Reset -> IDLE; outputs after reset: in_ready=1, out_valid=0, busy=0, result=0.
- IDLE: on handshake latch op/word, prepare operands, go CALC with counter N-1 (N=64, or 32 when word=1); special cases go straight to DONE with result written.
- Operand prep, word=1: use src[31:0], sign-extend for signed ops (MUL, DIV, REM), zero-extend for DIVU/REMU. word=1 with op 1-3 is treated as MULW.
- Signed ops (MULH, DIV, REM; src1 only for MULHSU): iterate on magnitudes, record signs; product negated if signs differ; quotient negated if signs differ; remainder takes sign of dividend.
- Multiply: 128-bit accumulator, one multiplier bit per cycle. MUL returns low 64, MULH* high 64.
- Divide: restoring, one quotient bit per cycle, 65-bit partial remainder.
- Special cases (1-cycle): divisor==0 -> quotient all ones, remainder = dividend; signed overflow (dividend = most-negative of width, divisor = -1) -> quotient = dividend, remainder 0. Width is 32 when word=1.
- Word results: result = sign-extend(bit 31 of 32-bit result) for every W op, including DIVUW/REMUW.
- CALC: decrement counter each cycle; at counter 0 apply sign fix-up, write result, go DONE.
- DONE: out_valid=1, result stable; on out_ready go IDLE. No new request accepted in DONE.
- flush (any state): next state IDLE, out_valid=0 next cycle, result register not updated; flush in IDLE with in_valid drops the request.
- rst mid-operation: identical to flush, plus result cleared to 0.

## Timing
- Handshake at cycle T, iterative path: out_valid first high at T+N+1 (T+65 for 64-bit, T+33 for W).
- Special cases: out_valid at T+1.
- Result consumed at cycle U (out_valid&out_ready): in_ready high at U+1; earliest next handshake U+1.
- flush at cycle F: busy=0, in_ready=1 at F+1.
- in_ready and busy are decoded from the state register only (no combinational path from inputs).

## Configuration
- YSYX_22050133_MDU_FAST_MUL_EN defined: all multiply ops use a single combinational 128-bit product and complete as special cases (out_valid at T+1); divide unchanged.
- Undefined: multiply is iterative, latency per Timing section; no wide multiplier synthesized.

## Test plan
- DIVU src1=100, src2=7 at T -> result 14, out_valid at T+65; REMU same operands -> 2.
- DIV src1=5, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REM same -> 5; DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000, REM -> 0.
- DIVW src1=0xFFFF_FFFF_FFFF_FFF9 (-7), src2=2 -> 0xFFFF_FFFF_FFFF_FFFD at T+33; REMW -> 0xFFFF_FFFF_FFFF_FFFF.
- MULH src1=src2=0xFFFF_FFFF_FFFF_FFFF -> 0; MULHU same -> 0xFFFF_FFFF_FFFF_FFFE; MULW 0x7FFF_FFFF*2 -> 0xFFFF_FFFF_FFFF_FFFE (T+33, or T+1 with FAST_MUL_EN).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result/out_valid stable, in_ready=0, in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- flush at T+20 of a DIV -> out_valid never asserts, in_ready=1 at T+21; following DIVU 9/3 returns 3 correctly.
